// File: rtl/program_counter_pkg.sv
// Shared CPU fetch constants: text-segment base, instruction size and address width.
package program_counter_pkg;

    localparam int          ADDR_W      = 32;
    localparam logic [31:0] TEXT_BASE   = 32'h0000_3000;
    localparam int          INSTR_BYTES = 4;

endpackage

// File: rtl/program_counter_if.sv
// Fetch-side bus between branch resolution (master) and the program counter (slave).
interface program_counter_if
    import program_counter_pkg::*;
#(
    parameter int WIDTH = ADDR_W
);

    logic             jumpEnabled;
    logic [WIDTH-1:0] jumpInput;
    logic [WIDTH-1:0] pcValue;

    modport master (
        output jumpEnabled,
        output jumpInput,
        input  pcValue
    );

    modport slave (
        input  jumpEnabled,
        input  jumpInput,
        output pcValue
    );

endinterface

// File: rtl/program_counter_next_sel.sv
// Combinational next-PC selection: reset vector, jump target, or sequential increment.
module program_counter_next_sel
    import program_counter_pkg::*;
#(
    parameter int               WIDTH        = ADDR_W,
    parameter logic [WIDTH-1:0] RESET_VECTOR = TEXT_BASE,
    parameter int               STEP         = INSTR_BYTES
) (
    input  logic             reset,
    input  logic             jump_enabled,
    input  logic [WIDTH-1:0] jump_input,
    input  logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] next_pc
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    // Reset beats jump beats increment; the add wraps modulo 2^WIDTH.
    always_comb begin
        next_pc = pc + STEP_W;
        if (reset) begin
            next_pc = RESET_VECTOR;
        end else if (jump_enabled) begin
            next_pc = jump_input;
        end
    end

endmodule

// File: rtl/program_counter.sv
// Instruction-fetch program counter: one register advancing by STEP or loading a jump target.
module program_counter
    import program_counter_pkg::*;
#(
    parameter int               WIDTH        = ADDR_W,
    parameter logic [WIDTH-1:0] RESET_VECTOR = TEXT_BASE,
    parameter int               STEP         = INSTR_BYTES
) (
    input  logic             clock,
    input  logic             reset,
    program_counter_if.slave bus
);

    logic [WIDTH-1:0] pc_p0;
    logic [WIDTH-1:0] next_pc;

    program_counter_next_sel #(
        .WIDTH        (WIDTH),
        .RESET_VECTOR (RESET_VECTOR),
        .STEP         (STEP)
    ) u_next_sel (
        .reset        (reset),
        .jump_enabled (bus.jumpEnabled),
        .jump_input   (bus.jumpInput),
        .pc           (pc_p0),
        .next_pc      (next_pc)
    );

    // Reset is folded into next_pc, so the register itself is a plain load.
    always_ff @(posedge clock) begin
        pc_p0 <= next_pc;
    end

    assign bus.pcValue = pc_p0;

`ifdef SIM
    localparam logic [WIDTH-1:0] STEP_CHK = WIDTH'(STEP);
    logic             seq_vld_p1;
    logic [WIDTH-1:0] pc_p1;

    always_ff @(posedge clock) begin
        seq_vld_p1 <= !reset && !bus.jumpEnabled;
        pc_p1      <= pc_p0;
        if (seq_vld_p1 === 1'b1) begin
            assert (pc_p0 == pc_p1 + STEP_CHK)
                else $error("pc did not advance by STEP after a sequential cycle");
        end
    end
`endif

endmodule

// File: tb/tb_program_counter.sv
// Directed and randomised-jump bench for program_counter with a queued expected-PC scoreboard.
module tb_program_counter;

    localparam int          W    = 32;
    localparam logic [31:0] RV   = 32'h0000_3000;
    localparam logic [31:0] STEP = 32'd4;

    logic clock;
    logic reset;

    program_counter_if #(.WIDTH(W)) bus ();

    program_counter #(
        .WIDTH        (W),
        .RESET_VECTOR (RV),
        .STEP         (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          passed = 0;
    int          total  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_pc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    endtask

    // Drive one cycle's inputs just after a falling edge, predict, then compare at the next falling edge.
    task automatic cycle(input string tag, input logic r, input logic je, input logic [31:0] ji,
                         input logic glitch);
        reset           = r;
        bus.jumpEnabled = je;
        bus.jumpInput   = ji;
        if (glitch) begin
            #1 bus.jumpEnabled = 1'b1;
            bus.jumpInput      = ~ji;
            #1 bus.jumpEnabled = je;
            bus.jumpInput      = ji;
        end
        if (r)       model_pc = RV;
        else if (je) model_pc = ji;
        else         model_pc = model_pc + STEP;
        exp_q.push_back(model_pc);
        @(posedge clock);
        @(negedge clock);
        if (exp_q.size() == 0) begin
            check({tag, "_empty_q"}, bus.pcValue, 32'hxxxx_xxxx);
        end else begin
            check(tag, bus.pcValue, exp_q.pop_front());
        end
    endtask

    initial begin
        reset           = 1'b0;
        bus.jumpEnabled = 1'b0;
        bus.jumpInput   = '0;
        model_pc        = '0;
        @(negedge clock);

        cycle("reset", 1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) cycle("seq_after_reset", 1'b0, 1'b0, 32'h0, 1'b0);
        check("seq_0x300c", bus.pcValue, 32'h0000_300C);

        for (int i = 0; i < 20; i++) cycle("seq20", 1'b0, 1'b0, 32'h0, i == 5);
        cycle("jump", 1'b0, 1'b1, 32'h1215_3524, 1'b0);
        check("jump_verbatim", bus.pcValue, 32'h1215_3524);
        cycle("jump_plus4", 1'b0, 1'b0, 32'h0, 1'b0);
        check("jump_plus4_abs", bus.pcValue, 32'h1215_3528);

        for (int i = 0; i < 3; i++) cycle("jump_held", 1'b0, 1'b1, 32'hC089_5E81, 1'b0);
        check("jump_held_abs", bus.pcValue, 32'hC089_5E81);
        cycle("jump_release", 1'b0, 1'b0, 32'h0, 1'b0);
        check("jump_release_abs", bus.pcValue, 32'hC089_5E85);

        cycle("wrap_jump", 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0);
        cycle("wrap_fffc", 1'b0, 1'b0, 32'h0, 1'b0);
        cycle("wrap_0000", 1'b0, 1'b0, 32'h0, 1'b0);
        check("wrap_zero_abs", bus.pcValue, 32'h0000_0000);
        cycle("wrap_0004", 1'b0, 1'b0, 32'h0, 1'b0);

        cycle("priority", 1'b1, 1'b1, 32'h8484_D609, 1'b0);
        check("priority_abs", bus.pcValue, RV);
        cycle("after_priority", 1'b0, 1'b0, 32'h0, 1'b0);
        check("after_priority_abs", bus.pcValue, 32'h0000_3004);

        for (int i = 0; i < 100; i++) begin
            if (i % 20 == 19) cycle("long_jump", 1'b0, 1'b1, $urandom, 1'b0);
            else              cycle("long_seq", 1'b0, 1'b0, $urandom, i % 7 == 3);
        end

        cycle("mid_reset", 1'b1, 1'b0, 32'h0, 1'b0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
